// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
//   Shared definitions for the iterative multiply/divide unit: the default
//   operand width, operation codes, FSM state encoding and two small
//   op-classification helpers used by both the control and datapath.
package mul_div_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if
//   Request / result bundle between the datapath (master) and the
//   multiply/divide unit (slave).
//   master -> slave : start, op, in1, in2, hi_we, lo_we, wdata
//   slave -> master : busy, done, hi, lo
interface mul_div_unit_if;
  import mul_div_unit_pkg::*;

  logic                     start;
  op_e                      op;
  logic [DEFAULT_WIDTH-1:0] in1;
  logic [DEFAULT_WIDTH-1:0] in2;
  logic                     hi_we;
  logic                     lo_we;
  logic [DEFAULT_WIDTH-1:0] wdata;
  logic                     busy;
  logic                     done;
  logic [DEFAULT_WIDTH-1:0] hi;
  logic [DEFAULT_WIDTH-1:0] lo;

  modport master (
    output start, op, in1, in2, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, in1, in2, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mul_div_unit_datapath_step.sv
// mdu_datapath_step
//   One combinational radix-2 iteration on the 2*WIDTH working register.
//   Multiply: work = {acc, multiplier}; adds operand to acc when the
//             multiplier LSB is set, then shifts the whole pair right.
//   Divide:   work = {rem, quotient}; shifts left by one, subtracts the
//             divisor (operand) when it fits and shifts in the quotient bit.
//   Ports:
//     op_i      operation code (selects multiply vs divide step)
//     operand_i multiplicand magnitude (multiply) or divisor magnitude (divide)
//     work_i    current working register
//     work_o    working register after one iteration
module mdu_datapath_step
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  op_e                  op_i,
  input  logic [WIDTH-1:0]     operand_i,
  input  logic [2*WIDTH-1:0]   work_i,
  output logic [2*WIDTH-1:0]   work_o
);

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic               fits;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    // Carry out of the accumulator add becomes the new acc MSB after the shift.
    add_sum  = {1'b0, work_i[2*WIDTH-1:WIDTH]}
             + (work_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
    mul_next = {add_sum, work_i[WIDTH-1:1]};

    // The shifted remainder needs one extra bit before the compare.
    rem_sh   = work_i[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, operand_i};
    fits     = (rem_sh >= {1'b0, operand_i});
    div_next = fits ? {diff[WIDTH-1:0],   work_i[WIDTH-2:0], 1'b1}
                    : {rem_sh[WIDTH-1:0], work_i[WIDTH-2:0], 1'b0};

    work_o   = is_div_op(op_i) ? div_next : mul_next;
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative MULT/MULTU/DIV/DIVU responder with directly writable HI/LO.
//   A start in IDLE latches operand magnitudes and sign flags, CALC runs
//   WIDTH radix-2 iterations, FIX applies sign correction, writes HI/LO and
//   pulses done. Total latency is WIDTH+1 cycles from the start edge.
//   Ports:
//     clk_i  rising-edge clock
//     rst_i  asynchronous active-high reset (aborts any operation)
//     bus    mul_div_unit_if slave: start/op/in1/in2/hi_we/lo_we/wdata in,
//            busy/done/hi/lo out
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input logic           clk_i,
  input logic           rst_i,
  mul_div_unit_if.slave bus
);

  localparam int W2 = 2 * WIDTH;

  state_e             state_q;
  op_e                op_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic [WIDTH-1:0]   operand_q;
  logic [WIDTH-1:0]   in1_q;
  logic [W2-1:0]      work_q;
  logic [W2-1:0]      work_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [W2-1:0]      prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;

  // Magnitudes are only taken for signed ops; unsigned ops pass raw values.
  always_comb begin
    a_neg = is_signed_op(bus.op) & bus.in1[WIDTH-1];
    b_neg = is_signed_op(bus.op) & bus.in2[WIDTH-1];
    mag_a = a_neg ? -bus.in1 : bus.in1;
    mag_b = b_neg ? -bus.in2 : bus.in2;
  end

  mdu_datapath_step #(
    .WIDTH     (WIDTH)
  ) u_step (
    .op_i      (op_q),
    .operand_i (operand_q),
    .work_i    (work_q),
    .work_o    (work_d)
  );

  // Sign correction and the divide-by-zero override, applied in FIX.
  always_comb begin
    prod = work_q;
    quot = work_q[WIDTH-1:0];
    rem  = work_q[W2-1:WIDTH];
    hi_d = hi_q;
    lo_d = lo_q;
    if ((op_q == OP_MULT) && (sign_a_q ^ sign_b_q)) begin
      prod = -work_q;
    end
    if (op_q == OP_DIV) begin
      if (sign_a_q ^ sign_b_q) quot = -work_q[WIDTH-1:0];
      if (sign_a_q)            rem  = -work_q[W2-1:WIDTH];
    end
    if (is_div_op(op_q)) begin
      // operand_q holds the divisor magnitude, zero only for a zero divisor.
      if (operand_q == '0) begin
        lo_d = '1;
        hi_d = in1_q;
      end else begin
        lo_d = quot;
        hi_d = rem;
      end
    end else begin
      hi_d = prod[W2-1:WIDTH];
      lo_d = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= OP_MULT;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      operand_q <= '0;
      in1_q     <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q     <= bus.op;
            sign_a_q <= a_neg;
            sign_b_q <= b_neg;
            in1_q    <= bus.in1;
            // Multiply iterates over in2 in the low half; divide over in1.
            if (is_div_op(bus.op)) begin
              operand_q <= mag_b;
              work_q    <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              operand_q <= mag_a;
              work_q    <= {{WIDTH{1'b0}}, mag_b};
            end
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        CALC: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
//   Directed plus small randomized stimulus for mul_div_unit. Expected HI/LO
//   results are queued when an operation is issued and compared by a monitor
//   when done pulses; control-path behaviour is checked inline.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] res;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input op_e op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    longint      sa;
    longint      sb;
    int          q;
    int          m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (op)
      OP_MULT:  r = 64'(sa * sb);
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        q = $signed(a) / $signed(b);
        m = $signed(a) % $signed(b);
        r = {32'(m), 32'(q)};
      end
      default:  r = {a % b, a / b};
    endcase
    return r;
  endfunction

  task automatic expect_res(input string tag, input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.res = {h, l};
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Drives a one-cycle start; returns #1 after the sampling edge.
  task automatic start_op(input op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.in1   = a;
    bus.in2   = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Waits (bounded) for done; checks cycles elapsed since the call.
  task automatic wait_done(input string tag, input int exp_lat, output int busy_cyc);
    int lat;
    lat      = 0;
    busy_cyc = (bus.busy === 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy === 1'b1) busy_cyc++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  // Result scoreboard: one queued expectation per done pulse.
  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) begin
      chk("done_has_expectation", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.tag, {bus.hi, bus.lo}, e.res);
        $display("done %s hi=%h lo=%h", e.tag, bus.hi, bus.lo);
      end
    end
  end

  initial begin
    int          bcyc;
    op_e         rop;
    logic [31:0] ra;
    logic [31:0] rb;

    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.in1   = '0;
    bus.in2   = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    step();

    // 1: MULTU max x max, busy for exactly 33 cycles, single done pulse
    expect_res("multu_ffff", 32'hFFFFFFFE, 32'h00000001);
    start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_ffff", 33, bcyc);
    chk("multu_busy_cycles", 64'(bcyc), 64'd33);
    step();
    chk("done_one_cycle", {62'd0, bus.busy, bus.done}, 64'd0);

    // 2: signed multiply and divide
    expect_res("mult_m7x6", 32'hFFFFFFFF, 32'hFFFFFFD6);
    start_op(OP_MULT, 32'hFFFFFFF9, 32'd6);
    wait_done("mult_m7x6", 33, bcyc);
    expect_res("div_m7d2", 32'hFFFFFFFF, 32'hFFFFFFFD);
    start_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div_m7d2", 33, bcyc);

    // 3: divide by zero, signed overflow
    expect_res("divu_by_zero", 32'd100, 32'hFFFFFFFF);
    start_op(OP_DIVU, 32'd100, 32'd0);
    wait_done("divu_by_zero", 33, bcyc);
    expect_res("div_overflow", 32'h00000000, 32'h80000000);
    start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_overflow", 33, bcyc);

    // 4: start while busy ignored; HI/LO hold during CALC; back-to-back
    expect_res("divu_100_7", 32'd2, 32'd14);
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (9) step();
    chk("calc_hold_hilo", {bus.hi, bus.lo}, {32'h00000000, 32'h80000000});
    start_op(OP_MULTU, 32'd3, 32'd3);
    chk("ignored_start_busy", {63'd0, bus.busy}, 64'd1);
    wait_done("divu_100_7", 23, bcyc);
    expect_res("b2b_multu_3x3", 32'd0, 32'd9);
    start_op(OP_MULTU, 32'd3, 32'd3);
    wait_done("b2b_multu_3x3", 33, bcyc);

    // 5: mthi/mtlo
    bus.hi_we = 1'b1;
    bus.wdata = 32'h12345678;
    step();
    bus.hi_we = 1'b0;
    chk("mthi_idle", {bus.hi, bus.lo}, {32'h12345678, 32'd9});
    expect_res("multu_5x5_a", 32'd0, 32'd25);
    start_op(OP_MULTU, 32'd5, 32'd5);
    bus.lo_we = 1'b1;
    bus.wdata = 32'hDEADBEEF;
    step();
    bus.lo_we = 1'b0;
    chk("mtlo_busy_ignored", {bus.hi, bus.lo}, {32'h12345678, 32'd9});
    wait_done("multu_5x5_a", 32, bcyc);
    bus.lo_we = 1'b1;
    bus.wdata = 32'hCAFEF00D;
    step();
    bus.lo_we = 1'b0;
    chk("mtlo_idle", {bus.hi, bus.lo}, {32'd0, 32'hCAFEF00D});
    expect_res("multu_6x8", 32'd0, 32'd48);
    bus.hi_we = 1'b1;
    bus.wdata = 32'hAAAAAAAA;
    start_op(OP_MULTU, 32'd6, 32'd8);
    bus.hi_we = 1'b0;
    chk("start_beats_mthi", {bus.hi, bus.lo}, {32'd0, 32'hCAFEF00D});
    wait_done("multu_6x8", 33, bcyc);

    // 6: asynchronous reset mid-divide
    start_op(OP_DIV, 32'hFFFFFF9C, 32'd7);
    repeat (14) step();
    chk("pre_reset_busy", {63'd0, bus.busy}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("async_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_reset_idle", {62'd0, bus.busy, bus.done}, 64'd0);
    expect_res("multu_5x5_b", 32'd0, 32'd25);
    start_op(OP_MULTU, 32'd5, 32'd5);
    wait_done("multu_5x5_b", 33, bcyc);

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      rop = op_e'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = $urandom();
      if (i < 4) rb = rb >> (i * 8);
      if (is_div_op(rop) && rb == 32'd0) rb = 32'd1;
      if (rop == OP_DIV && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
      begin
        logic [63:0] m;
        m = model(rop, ra, rb);
        expect_res($sformatf("rand%0d_op%0d", i, rop), m[63:32], m[31:0]);
      end
      start_op(rop, ra, rb);
      wait_done("rand", 33, bcyc);
    end

    step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
